irq_source_ctrl: RTL
====================

IRQ_SOURCE_CTRL -- requirements
Module: irq_source_ctrl

Interface
REQ-001 SHALL have parameter NLINES, default 32, meaning number of interrupt lines (1..32).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, meaning WAIT_ACK cycle limit (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ev_in  input  NLINES  raw peripheral event lines.
REQ-006 SHALL have port irq_out  output  NLINES  interrupt lines to the core's inirr input.
REQ-007 SHALL have port ack_in  input  NLINES  acknowledge lines from the core's outirr output.
REQ-008 SHALL have port wr_en  input  1  register write strobe.
REQ-009 SHALL have port rd_en  input  1  register read strobe.
REQ-010 SHALL have port addr  input  4  byte address; bits [1:0] are ignored.
REQ-011 SHALL have port wdata  input  32  write data.
REQ-012 SHALL have port rdata  output  32  read data, registered.
REQ-013 SHALL have port ready  output  1  one-cycle access-complete pulse.
REQ-014 SHALL have port timeout  output  1  sticky flag: an acknowledge timed out.

Function
REQ-015 Registers SHALL be: 0x0 PENDING (read; write-1-to-clear), 0x4 ENABLE (read/write), 0x8 EDGE (read/write; 1 = rising-edge line, 0 = level line), 0xC SWSET (write-only, write-1-to-set PENDING, reads 0).
REQ-016 An access SHALL pulse ready, and load rdata on reads, exactly one cycle after the wr_en or rd_en cycle; wr_en takes priority when both strobes are high.
REQ-017 Edge line: PENDING[i] SHALL set on the cycle after ev_in[i] goes 0->1; level line: PENDING[i] SHALL set every cycle ev_in[i] is 1.
REQ-018 Delivery FSM SHALL have states IDLE, WAIT_ACK and GAP.
REQ-019 In IDLE with (PENDING & ENABLE) != 0, the FSM SHALL latch the lowest-index such line as sel and move to WAIT_ACK on the next cycle.
REQ-020 In WAIT_ACK, irq_out SHALL be onehot(sel) and all other lines SHALL be 0; in IDLE and GAP, irq_out SHALL be 0.
REQ-021 In WAIT_ACK with ack_in[sel]=1, PENDING[sel] SHALL clear and the FSM SHALL enter GAP; other ack_in bits SHALL be ignored.
REQ-022 GAP SHALL last exactly one cycle, then return to IDLE.
REQ-023 If WAIT_ACK lasts ACK_TIMEOUT cycles with no acknowledge, the FSM SHALL enter GAP without clearing PENDING, and timeout SHALL be set.
REQ-024 timeout SHALL clear only on reset or on a write to PENDING with wdata[31]=1.
REQ-025 If ENABLE[sel] is cleared during WAIT_ACK, the FSM SHALL enter GAP on the next cycle with PENDING unchanged.
REQ-026 Simultaneous set and clear of a PENDING bit (event, SWSET, W1C, or ack) SHALL resolve to set.
REQ-027 PENDING bits at index NLINES or above SHALL read 0 and ignore writes.

Reset
REQ-028 While rst=1, the following SHALL hold: PENDING=0, ENABLE=0, EDGE=all ones, FSM=IDLE, irq_out=0, rdata=0, ready=0, timeout=0, edge-history=0.
REQ-029 Reset asserted mid-WAIT_ACK SHALL drop irq_out to 0 asynchronously.

Configuration
REQ-030 With IRQ_SRC_SYNC_EN defined, ev_in SHALL pass through a two-flop synchronizer, adding 2 cycles of event-to-PENDING latency.
REQ-031 Without IRQ_SRC_SYNC_EN, ev_in SHALL be sampled directly.

Structure
REQ-032 Package irq_src_pkg SHALL hold the register address constants, the FSM state encoding and the default ACK_TIMEOUT.
REQ-033 Sub-module irq_edge_det SHALL hold per-line sync (optional), edge history and set-pulse generation.

Verification
REQ-034 Scenario: ENABLE=0x4, EDGE=all ones, ev_in[2] pulsed one cycle -> PENDING=0x4, irq_out=0x4 two cycles later, ack_in=0x4 -> PENDING=0, irq_out=0 for at least one cycle.
REQ-035 Scenario: ENABLE=0x500, PENDING 0x100 and 0x400 set together -> irq_out=0x100 first, then after ack and GAP, irq_out=0x400.
REQ-036 Scenario: ACK_TIMEOUT=4, ENABLE=0x8, SWSET 0x8, no acknowledge -> irq_out=0x8 for 4 cycles, then 0 for 1 cycle, timeout=1, re-assert; write PENDING 0x80000000 -> timeout=0.
REQ-037 Scenario: EDGE=0, ev_in[0] held high, acknowledged -> PENDING[0] re-sets (set wins) and re-delivers.
REQ-038 Scenario: rst asserted during WAIT_ACK -> irq_out=0 immediately; all registers at reset values.
REQ-039 Scenario: read 0x8 after reset -> rdata=0xFFFFFFFF with ready one cycle after rd_en.

Source files
------------

// File: rtl/irq_src_pkg.sv
// rtl/irq_src_pkg.sv - register map, delivery FSM encoding and shared helpers for irq_source_ctrl
package irq_src_pkg;

   localparam logic [3:0] ADDR_PENDING = 4'h0;
   localparam logic [3:0] ADDR_ENABLE  = 4'h4;
   localparam logic [3:0] ADDR_EDGE    = 4'h8;
   localparam logic [3:0] ADDR_SWSET   = 4'hC;

   localparam int DEFAULT_ACK_TIMEOUT = 255;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ACK = 2'd1,
      ST_GAP      = 2'd2
   } irq_state_e;

   // Scans downward so the last hit written is the lowest set index.
   function automatic logic [4:0] lowest_set(input logic [31:0] v);
      logic [4:0] idx;
      idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/irq_edge_det.sv
// rtl/irq_edge_det.sv - per-line event sampling (two-flop sync under IRQ_SRC_SYNC_EN), edge history, set pulses
module irq_edge_det #(
   parameter int NLINES = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NLINES-1:0] ev_in,
   input  logic [NLINES-1:0] edge_mode,
   output logic [NLINES-1:0] set_pulse
);

   logic [NLINES-1:0] ev_s;
   logic [NLINES-1:0] hist_q, hist_d;

`ifdef IRQ_SRC_SYNC_EN
   logic [NLINES-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

   always_comb begin
      sync1_d = ev_in;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign ev_s = sync2_q;
`else
   assign ev_s = ev_in;
`endif

   always_comb begin
      hist_d    = ev_s;
      set_pulse = (edge_mode & ev_s & ~hist_q) | (~edge_mode & ev_s);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) hist_q <= '0;
      else     hist_q <= hist_d;
   end

endmodule

// File: rtl/irq_source_ctrl.sv
// rtl/irq_source_ctrl.sv - interrupt source controller with one-at-a-time delivery; option IRQ_SRC_SYNC_EN
module irq_source_ctrl
   import irq_src_pkg::*;
#(
   parameter int NLINES      = 32,
   parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NLINES-1:0] ev_in,
   output logic [NLINES-1:0] irq_out,
   input  logic [NLINES-1:0] ack_in,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [3:0]        addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              timeout
);

   logic [NLINES-1:0] pend_q, pend_d, en_q, en_d, edge_q, edge_d, irq_q, irq_d;
   logic [NLINES-1:0] set_pulse, set_v, clr_v, one_v;
   logic [31:0]       act_w, rdata_q, rdata_d;
   logic [4:0]        sel_q, sel_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              ready_q, ready_d, timeout_q, timeout_d, to_set, to_clr;
   logic [3:0]        word;
   logic              unused_addr_bits;
   irq_state_e        state_q, state_d;

   assign unused_addr_bits = ^addr[1:0];

   irq_edge_det #(.NLINES(NLINES)) u_edge_det (
      .clk       (clk),
      .rst       (rst),
      .ev_in     (ev_in),
      .edge_mode (edge_q),
      .set_pulse (set_pulse)
   );

   always_comb begin
      word     = {addr[3:2], 2'b00};
      en_d     = en_q;
      edge_d   = edge_q;
      set_v    = set_pulse;
      clr_v    = '0;
      to_clr   = 1'b0;
      to_set   = 1'b0;
      ready_d  = wr_en | rd_en;
      rdata_d  = rdata_q;
      one_v    = '0;
      one_v[0] = 1'b1;
      act_w    = '0;
      act_w[NLINES-1:0] = pend_q & en_q;

      if (wr_en) begin
         case (word)
            ADDR_PENDING: begin
               clr_v  = wdata[NLINES-1:0];
               to_clr = wdata[31];
            end
            ADDR_ENABLE: en_d   = wdata[NLINES-1:0];
            ADDR_EDGE:   edge_d = wdata[NLINES-1:0];
            ADDR_SWSET:  set_v  = set_v | wdata[NLINES-1:0];
            default: ;
         endcase
      end else if (rd_en) begin
         rdata_d = '0;
         case (word)
            ADDR_PENDING: rdata_d[NLINES-1:0] = pend_q;
            ADDR_ENABLE:  rdata_d[NLINES-1:0] = en_q;
            ADDR_EDGE:    rdata_d[NLINES-1:0] = edge_q;
            default: ;
         endcase
      end

      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (act_w != '0) begin
               sel_d   = lowest_set(act_w);
               cnt_d   = '0;
               state_d = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            // Only the acknowledge of the line being delivered counts.
            if (ack_in[sel_q]) begin
               clr_v[sel_q] = 1'b1;
               state_d      = ST_GAP;
            end else if (!en_q[sel_q]) begin
               state_d = ST_GAP;
            end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
               to_set  = 1'b1;
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Set sources are OR-ed in after clears so a coincident set wins.
      pend_d    = (pend_q & ~clr_v) | set_v;
      timeout_d = (timeout_q & ~to_clr) | to_set;
      irq_d     = (state_d == ST_WAIT_ACK) ? (one_v << sel_d) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q    <= '0;
         en_q      <= '0;
         edge_q    <= '1;
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         cnt_q     <= '0;
         irq_q     <= '0;
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         pend_q    <= pend_d;
         en_q      <= en_d;
         edge_q    <= edge_d;
         state_q   <= state_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         irq_q     <= irq_d;
         rdata_q   <= rdata_d;
         ready_q   <= ready_d;
         timeout_q <= timeout_d;
      end
   end

   assign irq_out = irq_q;
   assign rdata   = rdata_q;
   assign ready   = ready_q;
   assign timeout = timeout_q;

endmodule
